// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - per-channel polarity fix, two-flop synchroniser, debounce filter and edge pulses
// INPUT_CONDITIONER_DEBOUNCE_EN builds the stability counter; without it levels pass straight through the synchroniser.
module input_conditioner #(
   parameter int               WIDTH         = 4,
   parameter int               STABLE_CYCLES = 27000,
   parameter logic [WIDTH-1:0] INVERT_MASK   = 4'b1100
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_inputs,
   output logic [WIDTH-1:0] clean_inputs,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
);

   logic [WIDTH-1:0] sync0;
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_nxt;
   logic [WIDTH-1:0] commit;
   logic [WIDTH-1:0] rise_nxt;
   logic [WIDTH-1:0] fall_nxt;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;

   if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
      $error("input_conditioner: STABLE_CYCLES must be at least 2");
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync0  <= '0;
         sync1  <= '0;
         stable <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         sync0  <= raw_inputs ^ INVERT_MASK;
         sync1  <= sync0;
         stable <= stable_nxt;
         rise_q <= rise_nxt;
         fall_q <= fall_nxt;
      end
   end

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
   localparam int            CW   = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   logic [CW-1:0] count     [WIDTH];
   logic [CW-1:0] count_nxt [WIDTH];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '{default: '0};
      end else begin
         count <= count_nxt;
      end
   end

   // A channel is pending while sync1 disagrees with stable; agreement at any point drops the count.
   always_comb begin
      stable_nxt = stable;
      commit     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count_nxt[i] = '0;
         if (sync1[i] != stable[i]) begin
            if (count[i] == LAST) begin
               commit[i]     = 1'b1;
               stable_nxt[i] = sync1[i];
            end else begin
               count_nxt[i] = count[i] + CW'(1);
            end
         end
      end
   end
`else
   always_comb begin
      stable_nxt = sync1;
      commit     = sync1 ^ stable;
   end
`endif

   always_comb begin
      rise_nxt = commit & sync1;
      fall_nxt = commit & ~sync1;
   end

   assign clean_inputs = stable;
   assign rise_pulse   = rise_q;
   assign fall_pulse   = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - scoreboard bench for input_conditioner with STABLE_CYCLES=4
module tb_input_conditioner;

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif
   localparam int LAT = DEB ? 6 : 3;
   localparam int MID = DEB ? 4 : 2;

   typedef struct {
      int       cyc;
      logic [3:0] clean;
      logic [3:0] rise;
      logic [3:0] fall;
   } ev_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] raw_inputs;
   logic [3:0] clean_inputs;
   logic [3:0] rise_pulse;
   logic [3:0] fall_pulse;

   int   edge_n = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   ev_t  exp_q[$];
   ev_t  e;
   logic [3:0] cur_clean = '0;

   input_conditioner #(
      .WIDTH(4),
      .STABLE_CYCLES(4),
      .INVERT_MASK(4'b1100)
   ) dut (
      .clock(clock),
      .reset(reset),
      .raw_inputs(raw_inputs),
      .clean_inputs(clean_inputs),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse)
   );

   always #5 clock = ~clock;

   always @(posedge clock) edge_n++;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic push(input int d, input logic [3:0] c, input logic [3:0] r, input logic [3:0] f);
      ev_t x;
      x.cyc   = edge_n + d;
      x.clean = c;
      x.rise  = r;
      x.fall  = f;
      exp_q.push_back(x);
   endtask

   // Monitor: pops an expectation whenever a pulse appears, otherwise checks the level holds.
   always @(negedge clock) begin
      if (reset) begin
         n_chk++;
         if (clean_inputs != 4'b0 || rise_pulse != 4'b0 || fall_pulse != 4'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got clean=%b rise=%b fall=%b expected all zero",
                     clean_inputs, rise_pulse, fall_pulse);
         end
         cur_clean = '0;
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (dut.count[i] != 0) begin
               n_fail++;
               $display("FAIL reset_count[%0d]: got %0d expected 0", i, dut.count[i]);
            end
         end
`endif
      end else if (rise_pulse != 4'b0 || fall_pulse != 4'b0) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse at edge %0d: got rise=%b fall=%b expected none",
                     edge_n, rise_pulse, fall_pulse);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != edge_n || e.rise != rise_pulse || e.fall != fall_pulse || e.clean != clean_inputs) begin
               n_fail++;
               $display("FAIL pulse_event: got edge=%0d clean=%b rise=%b fall=%b expected edge=%0d clean=%b rise=%b fall=%b",
                        edge_n, clean_inputs, rise_pulse, fall_pulse, e.cyc, e.clean, e.rise, e.fall);
            end
            cur_clean = e.clean;
         end
      end else begin
         n_chk++;
         if (clean_inputs != cur_clean) begin
            n_fail++;
            $display("FAIL clean_hold at edge %0d: got %b expected %b", edge_n, clean_inputs, cur_clean);
         end
         if (exp_q.size() != 0 && exp_q[0].cyc <= edge_n) begin
            e = exp_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missed_pulse: got none by edge %0d expected rise=%b fall=%b at edge %0d",
                     edge_n, e.rise, e.fall, e.cyc);
            cur_clean = e.clean;
         end
      end
   end

   initial begin
      reset      = 1'b1;
      raw_inputs = 4'b1111;
      tick(3);

      // Release with ports 25/26 high and buttons idle.
      reset = 1'b0;
      push(LAT, 4'b0011, 4'b0011, 4'b0000);
      tick(LAT + 3);

      // Button 1 press and release.
      raw_inputs = 4'b1011;
      push(LAT, 4'b0111, 4'b0100, 4'b0000);
      tick(LAT + 3);
      raw_inputs = 4'b1111;
      push(LAT, 4'b0011, 4'b0000, 4'b0100);
      tick(LAT + 3);

      // Port 25 low, then a 3-cycle glitch.
      raw_inputs = 4'b1110;
      push(LAT, 4'b0010, 4'b0000, 4'b0001);
      tick(LAT + 3);
      raw_inputs = 4'b1111;
      if (!DEB) push(3, 4'b0011, 4'b0001, 4'b0000);
      tick(3);
      raw_inputs = 4'b1110;
      if (!DEB) push(3, 4'b0010, 4'b0000, 4'b0001);
      tick(LAT + 3);

      // Excursion of exactly STABLE_CYCLES is accepted.
      raw_inputs = 4'b1111;
      push(LAT, 4'b0011, 4'b0001, 4'b0000);
      tick(4);
      raw_inputs = 4'b1110;
      push(LAT, 4'b0010, 4'b0000, 4'b0001);
      tick(LAT + 3);

      // Port 26 low, then bounce 1,0,1,1,1,1,1.
      raw_inputs = 4'b1100;
      push(LAT, 4'b0000, 4'b0000, 4'b0010);
      tick(LAT + 3);
      raw_inputs = 4'b1110;
      if (!DEB) push(3, 4'b0010, 4'b0010, 4'b0000);
      tick(1);
      raw_inputs = 4'b1100;
      if (!DEB) push(3, 4'b0000, 4'b0000, 4'b0010);
      tick(1);
      raw_inputs = 4'b1110;
      push(LAT, 4'b0010, 4'b0010, 4'b0000);
      tick(LAT + 8);

      // Simultaneous changes on every channel.
      raw_inputs = 4'b0000;
      push(LAT, 4'b1100, 4'b1100, 4'b0010);
      tick(LAT + 3);
      raw_inputs = 4'b1111;
      push(LAT, 4'b0011, 4'b0011, 4'b1100);
      tick(LAT + 3);

      // Reset while button 1 is pending.
      raw_inputs = 4'b1011;
      tick(MID);
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      push(LAT, 4'b0111, 4'b0111, 4'b0000);
      tick(LAT + 4);

      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Synchronises and debounces the raw board inputs (analog ports 25/26 via comparators, buttons 1/2) before they reach the peripherals block's `input_peripherals[3:0]` port. Each channel gets optional polarity inversion, a two-flop synchroniser and a per-channel stability counter. Outputs are a clean level per channel plus one-cycle rise and fall event pulses. Channel mapping is unchanged: bit 0 is port 25, bit 1 is port 26, bit 2 is button 1, bit 3 is button 2.

## Interface
- `WIDTH`, 4: number of input channels.
- `STABLE_CYCLES`, 27000: consecutive cycles a changed level must persist before it is accepted; legal values are 2 or more.
- `INVERT_MASK`, 4'b1100: per-channel XOR applied to `raw_inputs` before the synchroniser; the onboard buttons are active-low.
- `clock`, input, 1: rising-edge clock, the same net as the peripherals block.
- `reset`, input, 1: asynchronous, active-high reset.
- `raw_inputs`, input, WIDTH: asynchronous pin levels.
- `clean_inputs`, output, WIDTH: debounced logical level; drives `input_peripherals`.
- `rise_pulse`, output, WIDTH: one-cycle high when `clean_inputs[i]` goes 0→1.
- `fall_pulse`, output, WIDTH: one-cycle high when `clean_inputs[i]` goes 1→0.

## Operation
- Per-channel pipeline:
  - `pin = raw_inputs[i] ^ INVERT_MASK[i]`
  - `sync0 <= pin`
  - `sync1 <= sync0`
  - Filter compares `sync1` against `stable`.
- Filter states per channel:
  - IDLE: `sync1 == stable`; `count` is held at 0.
  - PENDING: `sync1 != stable`; `count` increments by 1 per cycle.
- Transitions:
  - PENDING → IDLE with no commit if `sync1` returns to equal `stable` before the commit; `count` resets to 0. This is glitch rejection.
  - PENDING → IDLE with commit if `count == STABLE_CYCLES-1` and `sync1 != stable` at a rising edge. On that edge: `stable <= sync1`, `count <= 0`, and the matching pulse register is set.
- `count` width is `$clog2(STABLE_CYCLES)`. `count` never exceeds `STABLE_CYCLES-1`, so it cannot wrap.
- `clean_inputs = stable`, which is a registered output with no combinational path from `raw_inputs`.
- Pulse registers:
  - `rise_pulse[i] <= commit & sync1`
  - `fall_pulse[i] <= commit & ~sync1`
  - Both are cleared on every non-commit edge.
  - The two are never high together on one channel.
- Channels are fully independent. Simultaneous commits on several channels in one cycle are legal, and each channel raises its own pulse.
- Reset, including assertion mid-PENDING:
  - `sync0`, `sync1`, `stable`, `count` and both pulse registers are cleared to 0 immediately.
  - `clean_inputs = 0`, `rise_pulse = 0`, `fall_pulse = 0` while reset is high.
  - No pulse is emitted on reset entry or release.
  - After release, a channel whose `pin` is 1 follows the full latency and then produces a `rise_pulse`.

## Timing
- Every flop is on the rising edge of `clock`. Outputs settle well before the falling edge, where the peripherals block samples them.
- Latency: `pin` changes and then holds. The capture edge is edge 1. `clean_inputs` and the pulse change after edge `STABLE_CYCLES+2`.
- Pulse width is exactly 1 cycle.
- Minimum accepted pulse width at the pin is `STABLE_CYCLES` cycles, with a ±1 cycle synchroniser uncertainty. Shorter pin excursions produce no output activity.
- `STABLE_CYCLES=27000` at 27 MHz gives 1 ms.

## Configuration
- Macro: `INPUT_CONDITIONER_DEBOUNCE_EN`.
- Defined: the counter filter is compiled in, exactly as described above.
- Undefined:
  - No counter is built, and `STABLE_CYCLES` is ignored.
  - `stable <= sync1` on every edge.
  - Pulses fire whenever `sync1 != stable`.
  - Latency is 3 edges from the capture edge.
  - Reset values and pulse rules are unchanged.

## Test plan
All scenarios use `STABLE_CYCLES=4` and `INVERT_MASK=4'b1100` unless stated.
- Reset: hold `reset` high with `raw_inputs=4'b1111` → `clean_inputs=0`, no pulses. Release reset → `clean_inputs=4'b0011` and `rise_pulse=4'b0011` for 1 cycle after edge 6.
- Clean press: `raw_inputs[2]` goes 1→0 and holds → `clean_inputs[2]=1` after edge 6 and `rise_pulse[2]` high for exactly 1 cycle. Releasing it later gives `fall_pulse[2]` 6 edges after the release capture.
- Glitch: `raw_inputs[0]` is 1 for 3 cycles, then 0 → `clean_inputs[0]` stays 0, no pulses, `count` returns to 0.
- Bounce: `raw_inputs[1]` toggles 1,0,1,1,1,1,1 per cycle → exactly one `rise_pulse[1]`, 6 edges after the final stable capture.
- Simultaneous: all four channels change on the same cycle → all commit on the same edge. `rise_pulse=4'b0011` and `fall_pulse=4'b1100` (buttons released) in the same cycle.
- Reset mid-PENDING: assert `reset` while `count=2` → outputs are 0 immediately, `count=0`, no pulse.
- Macro-off build: `raw_inputs[0]` 0→1 → `clean_inputs[0]=1` after edge 3. A 1-cycle glitch propagates as one `rise_pulse` followed by one `fall_pulse`.
